sm_rx_bridge: RTL and testbench



---
 rtl/sm_rx_pkg.sv | 20 ++
 rtl/sm_rx_fifo.sv | 76 +++++++
 rtl/sm_rx_bridge.sv | 121 ++++++++++++
 tb/tb_sm_rx_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_rx_pkg.sv
// Shared types and field widths for the SM receive bridge.
package sm_rx_pkg;

  localparam int unsigned NODE_W = 16;
  localparam int unsigned GEN_W  = 12;
  localparam int unsigned OPR_W  = 32;
  localparam int unsigned WEN_W  = 2;
  localparam int unsigned PKT_W  = NODE_W + GEN_W + 2 * OPR_W + WEN_W;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic [WEN_W-1:0]  mem_wen;
  } sm_pkt_t;

  typedef enum logic {S_IDLE, S_ACK} sm_rx_state_e;

endpackage

// File: rtl/sm_rx_fifo.sv
// Circular packet FIFO with a registered head stage; a pushed entry becomes visible one edge
// after its push.
module sm_rx_fifo
  import sm_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  sm_pkt_t         push_pkt_i,
  input  logic            pop_i,
  output sm_pkt_t         head_o,
  output logic            head_valid_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  sm_pkt_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] avail;
  sm_pkt_t         head_q, head_d;
  logic            head_valid_q, head_valid_d;
  logic            push_ok, pop_ok;

  assign full_o       = (count_q == CntW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;
  assign push_ok      = push_i & ~full_o;
  assign pop_ok       = pop_i & head_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Only entries counted before this edge may reach the head register.
    avail        = pop_ok ? count_q - CntW'(1) : count_q;
    head_valid_d = (avail != '0);
    head_d       = head_valid_d ? mem_q[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_pkt_i;
  end

endmodule

// File: rtl/sm_rx_bridge.sv
// SM-side receiver for the FC1 4-phase active-low bundled-data link, feeding a valid/ready FIFO.
// Optional accepted-packet counter enabled by defining SM_RX_STATS_EN.
module sm_rx_bridge
  import sm_rx_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_n_i,
  input  logic [15:0] node_i,
  input  logic [11:0] gen_i,
  input  logic [31:0] opr0_i,
  input  logic [31:0] opr1_i,
  input  logic [1:0]  mem_wen_i,
  output logic        ack_n_o,
  output logic        pkt_valid_o,
  input  logic        pkt_ready_i,
  output logic [15:0] node_o,
  output logic [11:0] gen_o,
  output logic [31:0] opr0_o,
  output logic [31:0] opr1_o,
  output logic [1:0]  mem_wen_o,
  output logic        full_o
`ifdef SM_RX_STATS_EN
  ,
  output logic [15:0] pkt_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  sm_rx_state_e           state_q, state_d;
  logic                   ack_n_q, ack_n_d;
  logic                   push;
  logic                   fifo_full, fifo_empty;
  logic [CntW-1:0]        fifo_count;
  sm_pkt_t                push_pkt, head_pkt;
  logic                   unused_fifo_status;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], req_n_i};
  assign req_s  = sync_q[SYNC_STAGES-1];

  // Bundled data is only trusted once the synchronised request is low.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!req_s && !fifo_full) begin
          push    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (req_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ack_n_d = (state_d != S_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      ack_n_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_n_q <= ack_n_d;
    end
  end

  assign push_pkt = {node_i, gen_i, opr0_i, opr1_i, mem_wen_i};

  sm_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_pkt_i   (push_pkt),
    .pop_i        (pkt_valid_o & pkt_ready_i),
    .head_o       (head_pkt),
    .head_valid_o (pkt_valid_o),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign unused_fifo_status = ^{fifo_empty, fifo_count};

  assign ack_n_o   = ack_n_q;
  assign full_o    = fifo_full;
  assign node_o    = head_pkt.node;
  assign gen_o     = head_pkt.gen;
  assign opr0_o    = head_pkt.opr0;
  assign opr1_o    = head_pkt.opr1;
  assign mem_wen_o = head_pkt.mem_wen;

`ifdef SM_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (push && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_sm_rx_bridge.sv
// Bench for sm_rx_bridge: table-driven packets, scoreboard on the SM side, handshake corner cases.
module tb_sm_rx_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_n_i;
  logic [15:0] node_i;
  logic [11:0] gen_i;
  logic [31:0] opr0_i, opr1_i;
  logic [1:0]  mem_wen_i;
  logic        ack_n_o, pkt_valid_o, pkt_ready_i, full_o;
  logic [15:0] node_o;
  logic [11:0] gen_o;
  logic [31:0] opr0_o, opr1_o;
  logic [1:0]  mem_wen_o;
`ifdef SM_RX_STATS_EN
  logic [15:0] pkt_cnt;
`endif

  typedef struct {
    logic [15:0] node;
    logic [11:0] gen;
    logic [31:0] opr0;
    logic [31:0] opr1;
    logic [1:0]  wen;
    logic        exp_full;  // full_o after this packet is accepted with the consumer stalled
  } vec_t;

  vec_t          vecs[10];
  logic [93:0]   sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_popped = 0;

  sm_rx_bridge #(
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_n_i     (req_n_i),
    .node_i      (node_i),
    .gen_i       (gen_i),
    .opr0_i      (opr0_i),
    .opr1_i      (opr1_i),
    .mem_wen_i   (mem_wen_i),
    .ack_n_o     (ack_n_o),
    .pkt_valid_o (pkt_valid_o),
    .pkt_ready_i (pkt_ready_i),
    .node_o      (node_o),
    .gen_o       (gen_o),
    .opr0_o      (opr0_o),
    .opr1_o      (opr1_o),
    .mem_wen_o   (mem_wen_o),
    .full_o      (full_o)
`ifdef SM_RX_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [93:0] pk(input vec_t v);
    return {v.node, v.gen, v.opr0, v.opr1, v.wen};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic start_req(input int i);
    node_i    = vecs[i].node;
    gen_i     = vecs[i].gen;
    opr0_i    = vecs[i].opr0;
    opr1_i    = vecs[i].opr1;
    mem_wen_i = vecs[i].wen;
    req_n_i   = 1'b0;
    sb.push_back(pk(vecs[i]));
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int k = 0;
    while (ack_n_o !== lvl && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk(nm, ack_n_o, lvl);
  endtask

  task automatic send(input int i);
    start_req(i);
    wait_ack(1'b0, "send_ack_low");
    req_n_i = 1'b1;
    wait_ack(1'b1, "send_ack_high");
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk(nm, sb.size(), 0);
    chk({nm, "_valid"}, pkt_valid_o, 1'b0);
  endtask

  // SM-side consumer: every pop is compared against the oldest expected packet.
  initial begin
    logic [93:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && pkt_valid_o && pkt_ready_i) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL pop_unexpected: got %0h, want no packet",
                   {node_o, gen_o, opr0_o, opr1_o, mem_wen_o});
        end else begin
          exp = sb.pop_front();
          chk("pop_data", {node_o, gen_o, opr0_o, opr1_o, mem_wen_o}, exp);
        end
        n_popped++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int p0;
    vecs[0] = '{16'h1234, 12'hABC, 32'hDEADBEEF, 32'h1, 2'b01, 1'b0};
    for (int i = 1; i < 10; i++) begin
      vecs[i] = '{16'(16'h1000 + i), 12'(12'h100 * i + 3), 32'hA5A50000 ^ 32'(i),
                  $urandom(), 2'(i), (i == 4)};
    end

    rst = 1'b1; req_n_i = 1'b1; pkt_ready_i = 1'b0;
    node_i = '0; gen_i = '0; opr0_i = '0; opr1_i = '0; mem_wen_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack_n", ack_n_o, 1'b1);
    chk("rst_valid", pkt_valid_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_data", {node_o, gen_o, opr0_o, opr1_o, mem_wen_o}, 94'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single packet with exact capture/release timing.
    start_req(0);
    repeat (2) @(negedge clk);
    chk("cap_clk2_ack", ack_n_o, 1'b1);
    @(negedge clk);
    chk("cap_clk3_ack", ack_n_o, 1'b0);
    chk("cap_clk3_valid", pkt_valid_o, 1'b0);
    @(negedge clk);
    chk("cap_clk4_valid", pkt_valid_o, 1'b1);
    chk("cap_clk4_fields", {node_o, gen_o, opr0_o, opr1_o, mem_wen_o}, pk(vecs[0]));
    req_n_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_clk2_ack", ack_n_o, 1'b0);
    @(negedge clk);
    chk("rel_clk3_ack", ack_n_o, 1'b1);
    pkt_ready_i = 1'b1;
    @(negedge clk);
    pkt_ready_i = 1'b0;
    chk("pop_valid_low", pkt_valid_o, 1'b0);
    chk("head_hold", node_o, 16'h1234);

    // Backpressure: four fill the FIFO, the fifth waits for a pop.
    for (int i = 1; i <= 4; i++) begin
      send(i);
      chk("bp_full", full_o, vecs[i].exp_full);
    end
    start_req(5);
    repeat (8) @(negedge clk);
    chk("bp_fifth_unacked", ack_n_o, 1'b1);
    chk("bp_full_held", full_o, 1'b1);
    pkt_ready_i = 1'b1;
    @(negedge clk);
    pkt_ready_i = 1'b0;
    wait_ack(1'b0, "bp_fifth_acked");
    req_n_i = 1'b1;
    wait_ack(1'b1, "bp_fifth_release");
    pkt_ready_i = 1'b1;
    drain("bp_drain");
    chk("bp_full_after", full_o, 1'b0);

    // Wrap-around with the consumer always ready.
    p0 = n_popped;
    for (int i = 0; i < 10; i++) send(i);
    drain("wrap_drain");
    chk("wrap_pops", n_popped - p0, 10);
    chk("wrap_full", full_o, 1'b0);

    // Held request: exactly one push regardless of how long req_n stays low.
    pkt_ready_i = 1'b0;
    p0 = n_popped;
    start_req(2);
    wait_ack(1'b0, "held_ack_low");
    repeat (20) @(negedge clk);
    chk("held_ack_stays", ack_n_o, 1'b0);
    pkt_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_one_push", n_popped - p0, 1);
    chk("held_valid", pkt_valid_o, 1'b0);
    req_n_i = 1'b1;
    wait_ack(1'b1, "held_release");
    pkt_ready_i = 1'b0;

    // Reset while in ACK with a packet queued.
    start_req(3);
    wait_ack(1'b0, "rst_ack_phase");
    @(negedge clk);
    chk("rst_pre_valid", pkt_valid_o, 1'b1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ack_n", ack_n_o, 1'b1);
    chk("rst_mid_valid", pkt_valid_o, 1'b0);
    sb.push_back(pk(vecs[3]));
    p0 = n_popped;
    wait_ack(1'b0, "rst_recapture");
    pkt_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_one_recapture", n_popped - p0, 1);
    req_n_i = 1'b1;
    wait_ack(1'b1, "rst_release");
    drain("rst_drain");

`ifdef SM_RX_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 6; i < 9; i++) send(i);
    drain("stats_drain");
    chk("stats_count3", pkt_cnt, 16'd3);
    force dut.pkt_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.pkt_cnt_q;
    for (int i = 6; i < 9; i++) send(i);
    drain("stats_sat_drain");
    chk("stats_saturate", pkt_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
